timer32_sched_ctrl: RTL

// - Bus-master sequencer for one timer32 instance: plays a host-loaded table of

---
 rtl/timer32_sched_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/timer32_sched_ctrl.sv
// Sequencer that plays a table of timer periods through one timer32 register port,
// reporting each expiry. All outputs are registered; reset also clears the table.
module timer32_sched_ctrl #(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [31:0]   cfg_period,
  input  logic [IW:0]   cfg_len,
  input  logic          cfg_loop,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          event_pulse,
  output logic [IW-1:0] event_idx,
  output logic          done,
  output logic          tmr_wren,
  output logic          tmr_rden,
  output logic [1:0]    tmr_addr,
  output logic [31:0]   tmr_din,
  input  logic [31:0]   tmr_dout
);

  typedef enum logic [3:0] {
    IDLE, SKIPCHK, LOAD_PR, CLR_CNT, ENABLE, POLL, EXPIRE, ADVANCE, HALT
  } state_t;

  localparam logic [1:0] A_COUNT  = 2'd0;
  localparam logic [1:0] A_PERIOD = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);
  localparam logic [IW:0] ONE_W   = (IW+1)'(1);

  state_t       state;
  logic [IW:0]  idx;
  logic [IW:0]  len_q;
  logic         loop_q;
  logic         exp_tog;
  logic [31:0]  tbl [DEPTH];

  logic [IW:0]  len_eff;
  logic         last;
  logic [31:0]  cur_period;
  logic         unused_dout;

  // Out-of-range lengths fall back to the full table.
  always_comb begin
    len_eff = cfg_len;
    if (cfg_len == '0 || cfg_len > DEPTH_W)
      len_eff = DEPTH_W;
  end

  assign last        = (idx == len_q - ONE_W);
  assign cur_period  = tbl[idx[IW-1:0]];
  assign unused_dout = ^{tmr_dout[31:3], tmr_dout[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      exp_tog     <= 1'b0;
      busy        <= 1'b0;
      event_pulse <= 1'b0;
      event_idx   <= '0;
      done        <= 1'b0;
      tmr_wren    <= 1'b0;
      tmr_rden    <= 1'b0;
      tmr_addr    <= '0;
      tmr_din     <= '0;
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= '0;
    end else begin
      tmr_wren    <= 1'b0;
      tmr_rden    <= 1'b0;
      tmr_addr    <= '0;
      tmr_din     <= '0;
      event_pulse <= 1'b0;
      event_idx   <= '0;
      done        <= 1'b0;

      if (state == IDLE && cfg_we)
        tbl[cfg_idx] <= cfg_period;

      // Bus outputs are set on the transition so they are visible during the named state.
      if (stop && state != IDLE && state != HALT) begin
        state    <= HALT;
        busy     <= 1'b1;
        tmr_wren <= 1'b1;
        tmr_addr <= A_CTRL;
        tmr_din  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len_q  <= len_eff;
              loop_q <= cfg_loop;
              idx    <= '0;
              busy   <= 1'b1;
              state  <= SKIPCHK;
            end
          end
          SKIPCHK: begin
            if (cur_period == '0) begin
              done  <= last && !loop_q;
              state <= ADVANCE;
            end else begin
              tmr_wren <= 1'b1;
              tmr_addr <= A_PERIOD;
              tmr_din  <= cur_period;
              state    <= LOAD_PR;
            end
          end
          LOAD_PR: begin
            tmr_wren <= 1'b1;
            tmr_addr <= A_COUNT;
            tmr_din  <= '0;
            state    <= CLR_CNT;
          end
          CLR_CNT: begin
            tmr_wren <= 1'b1;
            tmr_addr <= A_CTRL;
            tmr_din  <= 32'd1;
            exp_tog  <= 1'b0;
            state    <= ENABLE;
          end
          ENABLE: begin
            tmr_rden <= 1'b1;
            tmr_addr <= A_CTRL;
            state    <= POLL;
          end
          POLL: begin
            // Toggle, not flag: the polling read itself clears flag.
            if (tmr_dout[2] != exp_tog) begin
              tmr_wren    <= 1'b1;
              tmr_addr    <= A_CTRL;
              tmr_din     <= '0;
              event_pulse <= 1'b1;
              event_idx   <= idx[IW-1:0];
              state       <= EXPIRE;
            end else begin
              tmr_rden <= 1'b1;
              tmr_addr <= A_CTRL;
            end
          end
          EXPIRE: begin
            done  <= last && !loop_q;
            state <= ADVANCE;
          end
          ADVANCE: begin
            if (last) begin
              if (loop_q) begin
                idx   <= '0;
                state <= SKIPCHK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              idx   <= idx + ONE_W;
              state <= SKIPCHK;
            end
          end
          HALT: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
